// File: rtl/bolme_pkg.sv
// Shared definitions for the divide issue queue: opcode encodings,
// FSM state type and the opcode one-hot check.
package bolme_pkg;

    localparam logic [3:0] ISLEV_DIV  = 4'b0001;
    localparam logic [3:0] ISLEV_DIVU = 4'b0010;
    localparam logic [3:0] ISLEV_REM  = 4'b0100;
    localparam logic [3:0] ISLEV_REMU = 4'b1000;

    typedef enum logic [1:0] {
        BOSTA  = 2'd0,
        GONDER = 2'd1,
        BEKLE  = 2'd2,
        SONUC  = 2'd3
    } durum_t;

    // True when exactly one bit of the opcode is set.
    function automatic logic tek_sicak(input logic [3:0] kod);
        return (kod != 4'b0000) && ((kod & (kod - 4'd1)) == 4'b0000);
    endfunction

endpackage

// File: rtl/bolme_fifo.sv
// Generic synchronous FIFO with flush.
//   clk_g, rst_g : clock, asynchronous active-low reset
//   itme / giris : push strobe and data (ignored when full or flushing)
//   cekme        : pop strobe (ignored when empty or flushing)
//   temizle      : flush; empties the FIFO at the next edge
//   cikis        : head entry, valid while bos is low
//   dolu / bos   : full / empty flags
module bolme_fifo #(
    parameter int GENISLIK = 8,
    parameter int DERINLIK = 4
) (
    input  logic                clk_g,
    input  logic                rst_g,
    input  logic                itme,
    input  logic                cekme,
    input  logic                temizle,
    input  logic [GENISLIK-1:0] giris,
    output logic [GENISLIK-1:0] cikis,
    output logic                dolu,
    output logic                bos
);
    localparam int AW = $clog2(DERINLIK);
    localparam logic [AW:0] DOLU_SAYI = (AW + 1)'(DERINLIK);

    logic [GENISLIK-1:0] bellek [DERINLIK];
    logic [AW-1:0]       yaz;
    logic [AW-1:0]       oku;
    logic [AW:0]         sayi;
    logic                itme_ok;
    logic                cekme_ok;

    assign itme_ok  = itme  & ~dolu & ~temizle;
    assign cekme_ok = cekme & ~bos  & ~temizle;
    assign dolu     = (sayi == DOLU_SAYI);
    assign bos      = (sayi == '0);
    assign cikis    = bellek[oku];

    // Depth is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk_g or negedge rst_g) begin
        if (!rst_g) begin
            yaz  <= '0;
            oku  <= '0;
            sayi <= '0;
        end else if (temizle) begin
            yaz  <= '0;
            oku  <= '0;
            sayi <= '0;
        end else begin
            if (itme_ok)  yaz <= yaz + 1'b1;
            if (cekme_ok) oku <= oku + 1'b1;
            case ({itme_ok, cekme_ok})
                2'b10:   sayi <= sayi + 1'b1;
                2'b01:   sayi <= sayi - 1'b1;
                default: sayi <= sayi;
            endcase
        end
    end

    always_ff @(posedge clk_g) begin
        if (itme_ok) bellek[yaz] <= giris;
    end

endmodule

// File: rtl/bolme_is_sirasi.sv
// Issue/queue stage in front of the integer divide unit.
//   istek_*   : request handshake from execute (opcode one-hot, operands, tag)
//   iptal_g   : flush of queued and in-flight work
//   bolme_*   : start pulse, opcode and operands to the divider; bitti/sonuc back
//   sonuc_*   : result handshake to the consumer, with destination tag
//   bos_c     : queue empty and idle
//   gecersiz_c, zaman_asimi_c : one-cycle pulses for dropped opcode / watchdog
module bolme_is_sirasi
    import bolme_pkg::*;
#(
    parameter int DERINLIK    = 4,
    parameter int ETIKET_W    = 5,
    parameter int ZAMAN_ASIMI = 64
) (
    input  logic                clk_g,
    input  logic                rst_g,
    input  logic                istek_gecerli_g,
    output logic                istek_hazir_c,
    input  logic [3:0]          istek_islev_kodu_g,
    input  logic [31:0]         istek_islec1_g,
    input  logic [31:0]         istek_islec2_g,
    input  logic [ETIKET_W-1:0] istek_etiket_g,
    input  logic                iptal_g,
    output logic                bolme_hazir_c,
    output logic [3:0]          bolme_islev_kodu_c,
    output logic [31:0]         bolme_islec1_c,
    output logic [31:0]         bolme_islec2_c,
    input  logic                bolme_bitti_g,
    input  logic [31:0]         bolme_sonuc_g,
    output logic                sonuc_gecerli_c,
    input  logic                sonuc_hazir_g,
    output logic [31:0]         sonuc_c,
    output logic [ETIKET_W-1:0] sonuc_etiket_c,
    output logic                bos_c,
    output logic                gecersiz_c,
    output logic                zaman_asimi_c
);
    localparam int GENISLIK = 4 + 64 + ETIKET_W;
    localparam int SW       = $clog2(ZAMAN_ASIMI + 1);
    localparam logic [SW-1:0] SAYAC_SON = SW'(ZAMAN_ASIMI - 1);

    durum_t              durum;
    logic                fifo_dolu;
    logic                fifo_bos;
    logic [GENISLIK-1:0] fifo_cikis;
    logic                kabul;
    logic                itme;
    logic                cek;
    logic [3:0]          bas_islev;
    logic [31:0]         bas_islec1;
    logic [31:0]         bas_islec2;
    logic [ETIKET_W-1:0] bas_etiket;
    logic [ETIKET_W-1:0] is_etiket;
    logic                dusur;
    logic [SW-1:0]       sayac;

    assign istek_hazir_c = ~fifo_dolu;
    assign kabul = istek_gecerli_g & istek_hazir_c & ~iptal_g;
    assign itme  = kabul & tek_sicak(istek_islev_kodu_g);
    // Head is popped on the edge that enters GONDER, so the start pulse and
    // the operands appear together in the following cycle.
    assign cek   = ~fifo_bos & ~iptal_g &
                   ((durum == BOSTA) | ((durum == SONUC) & sonuc_hazir_g));
    assign {bas_islev, bas_islec1, bas_islec2, bas_etiket} = fifo_cikis;
    assign bos_c = fifo_bos & (durum == BOSTA);

    bolme_fifo #(
        .GENISLIK (GENISLIK),
        .DERINLIK (DERINLIK)
    ) u_fifo (
        .clk_g   (clk_g),
        .rst_g   (rst_g),
        .itme    (itme),
        .cekme   (cek),
        .temizle (iptal_g),
        .giris   ({istek_islev_kodu_g, istek_islec1_g, istek_islec2_g, istek_etiket_g}),
        .cikis   (fifo_cikis),
        .dolu    (fifo_dolu),
        .bos     (fifo_bos)
    );

    always_ff @(posedge clk_g or negedge rst_g) begin
        if (!rst_g) begin
            durum              <= BOSTA;
            bolme_hazir_c      <= 1'b0;
            bolme_islev_kodu_c <= '0;
            bolme_islec1_c     <= '0;
            bolme_islec2_c     <= '0;
            is_etiket          <= '0;
            dusur              <= 1'b0;
            sayac              <= '0;
            sonuc_gecerli_c    <= 1'b0;
            sonuc_c            <= '0;
            sonuc_etiket_c     <= '0;
            gecersiz_c         <= 1'b0;
            zaman_asimi_c      <= 1'b0;
        end else begin
            bolme_hazir_c <= 1'b0;
            zaman_asimi_c <= 1'b0;
            gecersiz_c    <= kabul & ~tek_sicak(istek_islev_kodu_g);

            if (cek) begin
                bolme_islev_kodu_c <= bas_islev;
                bolme_islec1_c     <= bas_islec1;
                bolme_islec2_c     <= bas_islec2;
                is_etiket          <= bas_etiket;
                bolme_hazir_c      <= 1'b1;
            end

            case (durum)
                BOSTA: begin
                    if (cek) durum <= GONDER;
                end
                GONDER: begin
                    durum <= BEKLE;
                    sayac <= '0;
                    dusur <= iptal_g;
                end
                BEKLE: begin
                    if (bolme_bitti_g) begin
                        // A flushed op still owns the divider until its bitti.
                        if (dusur | iptal_g) begin
                            durum <= BOSTA;
                        end else begin
                            sonuc_c         <= bolme_sonuc_g;
                            sonuc_etiket_c  <= is_etiket;
                            sonuc_gecerli_c <= 1'b1;
                            durum           <= SONUC;
                        end
                        dusur <= 1'b0;
                    end else if (sayac == SAYAC_SON) begin
                        zaman_asimi_c <= 1'b1;
                        dusur         <= 1'b0;
                        durum         <= BOSTA;
                    end else begin
                        sayac <= sayac + 1'b1;
                        if (iptal_g) dusur <= 1'b1;
                    end
                end
                SONUC: begin
                    if (iptal_g) begin
                        sonuc_gecerli_c <= 1'b0;
                        durum           <= BOSTA;
                    end else if (sonuc_hazir_g) begin
                        sonuc_gecerli_c <= 1'b0;
                        durum           <= cek ? GONDER : BOSTA;
                    end
                end
                default: durum <= BOSTA;
            endcase
        end
    end

endmodule

// File: tb/tb_bolme_is_sirasi.sv
module tb_bolme_is_sirasi;
    logic        clk_g = 1'b0;
    logic        rst_g = 1'b1;
    logic        istek_gecerli_g = 1'b0;
    logic        istek_hazir_c;
    logic [3:0]  istek_islev_kodu_g = '0;
    logic [31:0] istek_islec1_g = '0;
    logic [31:0] istek_islec2_g = '0;
    logic [4:0]  istek_etiket_g = '0;
    logic        iptal_g = 1'b0;
    logic        bolme_hazir_c;
    logic [3:0]  bolme_islev_kodu_c;
    logic [31:0] bolme_islec1_c;
    logic [31:0] bolme_islec2_c;
    logic        bolme_bitti_g = 1'b0;
    logic [31:0] bolme_sonuc_g = '0;
    logic        sonuc_gecerli_c;
    logic        sonuc_hazir_g = 1'b0;
    logic [31:0] sonuc_c;
    logic [4:0]  sonuc_etiket_c;
    logic        bos_c;
    logic        gecersiz_c;
    logic        zaman_asimi_c;

    int total = 0;
    int bad   = 0;

    bolme_is_sirasi #(
        .DERINLIK    (4),
        .ETIKET_W    (5),
        .ZAMAN_ASIMI (64)
    ) dut (
        .clk_g              (clk_g),
        .rst_g              (rst_g),
        .istek_gecerli_g    (istek_gecerli_g),
        .istek_hazir_c      (istek_hazir_c),
        .istek_islev_kodu_g (istek_islev_kodu_g),
        .istek_islec1_g     (istek_islec1_g),
        .istek_islec2_g     (istek_islec2_g),
        .istek_etiket_g     (istek_etiket_g),
        .iptal_g            (iptal_g),
        .bolme_hazir_c      (bolme_hazir_c),
        .bolme_islev_kodu_c (bolme_islev_kodu_c),
        .bolme_islec1_c     (bolme_islec1_c),
        .bolme_islec2_c     (bolme_islec2_c),
        .bolme_bitti_g      (bolme_bitti_g),
        .bolme_sonuc_g      (bolme_sonuc_g),
        .sonuc_gecerli_c    (sonuc_gecerli_c),
        .sonuc_hazir_g      (sonuc_hazir_g),
        .sonuc_c            (sonuc_c),
        .sonuc_etiket_c     (sonuc_etiket_c),
        .bos_c              (bos_c),
        .gecersiz_c         (gecersiz_c),
        .zaman_asimi_c      (zaman_asimi_c)
    );

    always #5 clk_g = ~clk_g;

    initial begin
        #300000;
        $display("FAIL sim_timeout: got running want finished");
        $fatal(1);
    end

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk_g);
        #1;
    endtask

    task automatic istek(input logic [3:0] k, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] e);
        istek_gecerli_g    = 1'b1;
        istek_islev_kodu_g = k;
        istek_islec1_g     = a;
        istek_islec2_g     = b;
        istek_etiket_g     = e;
    endtask

    task automatic istek_bitir();
        istek_gecerli_g    = 1'b0;
        istek_islev_kodu_g = '0;
    endtask

    task automatic test_reset();
        #1 rst_g = 1'b0;
        #2;
        total++; if (istek_hazir_c !== 1'b1) begin bad++; $display("FAIL reset_istek_hazir: got %b want 1", istek_hazir_c); end
        total++; if (bos_c !== 1'b1) begin bad++; $display("FAIL reset_bos: got %b want 1", bos_c); end
        total++; if (bolme_hazir_c !== 1'b0) begin bad++; $display("FAIL reset_bolme_hazir: got %b want 0", bolme_hazir_c); end
        total++; if (sonuc_gecerli_c !== 1'b0) begin bad++; $display("FAIL reset_sonuc_gecerli: got %b want 0", sonuc_gecerli_c); end
        total++; if (sonuc_c !== 32'd0) begin bad++; $display("FAIL reset_sonuc: got %0h want 0", sonuc_c); end
        total++; if ({gecersiz_c, zaman_asimi_c} !== 2'b00) begin bad++; $display("FAIL reset_pulses: got %b want 00", {gecersiz_c, zaman_asimi_c}); end
        tick();
        tick();
        rst_g = 1'b1;
        tick();
    endtask

    task automatic test_single();
        istek(4'h1, 32'd100, 32'd7, 5'd3);
        tick();
        istek_bitir();
        total++; if (bolme_hazir_c !== 1'b0) begin bad++; $display("FAIL single_no_early_hazir: got %b want 0", bolme_hazir_c); end
        total++; if (bos_c !== 1'b0) begin bad++; $display("FAIL single_bos_low: got %b want 0", bos_c); end
        tick();
        total++; if (bolme_hazir_c !== 1'b1) begin bad++; $display("FAIL single_hazir: got %b want 1", bolme_hazir_c); end
        total++; if (bolme_islev_kodu_c !== 4'h1) begin bad++; $display("FAIL single_islev: got %0h want 1", bolme_islev_kodu_c); end
        tick();
        total++; if (bolme_hazir_c !== 1'b0) begin bad++; $display("FAIL single_hazir_one_cycle: got %b want 0", bolme_hazir_c); end
        for (int i = 0; i < 3; i++) begin
            total++; if ({bolme_islec1_c, bolme_islec2_c} !== {32'd100, 32'd7}) begin bad++; $display("FAIL single_ops_stable: got %0h/%0h want 64/7", bolme_islec1_c, bolme_islec2_c); end
            tick();
        end
        bolme_bitti_g = 1'b1;
        bolme_sonuc_g = 32'd14;
        tick();
        bolme_bitti_g = 1'b0;
        total++; if (sonuc_gecerli_c !== 1'b1) begin bad++; $display("FAIL single_gecerli: got %b want 1", sonuc_gecerli_c); end
        total++; if (sonuc_c !== 32'd14) begin bad++; $display("FAIL single_sonuc: got %0d want 14", sonuc_c); end
        total++; if (sonuc_etiket_c !== 5'd3) begin bad++; $display("FAIL single_etiket: got %0d want 3", sonuc_etiket_c); end
        sonuc_hazir_g = 1'b1;
        tick();
        sonuc_hazir_g = 1'b0;
        total++; if (sonuc_gecerli_c !== 1'b0) begin bad++; $display("FAIL single_gecerli_drop: got %b want 0", sonuc_gecerli_c); end
        total++; if (bos_c !== 1'b1) begin bad++; $display("FAIL single_bos_after: got %b want 1", bos_c); end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  k   [5];
        logic [31:0] a   [5];
        logic [31:0] b   [5];
        logic [31:0] sn  [5];
        logic [4:0]  e   [5];
        k[0] = 4'h8; a[0] = 32'd100;        b[0] = 32'd7;        sn[0] = 32'd2;          e[0] = 5'd11;
        k[1] = 4'h2; a[1] = 32'd9;          b[1] = 32'd3;        sn[1] = 32'd3;          e[1] = 5'd12;
        k[2] = 4'h4; a[2] = 32'hFFFF_FFF9;  b[2] = 32'd2;        sn[2] = 32'hFFFF_FFFF;  e[2] = 5'd13;
        k[3] = 4'h1; a[3] = 32'h8000_0000;  b[3] = 32'hFFFF_FFFF; sn[3] = 32'h8000_0000; e[3] = 5'd14;
        k[4] = 4'h2; a[4] = 32'd20;         b[4] = 32'd4;        sn[4] = 32'd5;          e[4] = 5'd15;
        for (int i = 0; i < 5; i++) begin
            istek(k[i], a[i], b[i], e[i]);
            tick();
        end
        istek_bitir();
        total++; if (istek_hazir_c !== 1'b0) begin bad++; $display("FAIL b2b_full_ready: got %b want 0", istek_hazir_c); end
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin
                total++; if (bolme_hazir_c !== 1'b1) begin bad++; $display("FAIL b2b_next_hazir[%0d]: got %b want 1", i, bolme_hazir_c); end
            end
            total++; if ({bolme_islev_kodu_c, bolme_islec1_c, bolme_islec2_c} !== {k[i], a[i], b[i]}) begin bad++; $display("FAIL b2b_issue[%0d]: got %0h/%0h/%0h want %0h/%0h/%0h", i, bolme_islev_kodu_c, bolme_islec1_c, bolme_islec2_c, k[i], a[i], b[i]); end
            tick();
            tick();
            bolme_bitti_g = 1'b1;
            bolme_sonuc_g = sn[i];
            tick();
            bolme_bitti_g = 1'b0;
            total++; if ({sonuc_gecerli_c, sonuc_c, sonuc_etiket_c} !== {1'b1, sn[i], e[i]}) begin bad++; $display("FAIL b2b_result[%0d]: got v=%b %0h t=%0d want v=1 %0h t=%0d", i, sonuc_gecerli_c, sonuc_c, sonuc_etiket_c, sn[i], e[i]); end
            sonuc_hazir_g = 1'b1;
            tick();
            sonuc_hazir_g = 1'b0;
            if (i == 0) begin
                total++; if (istek_hazir_c !== 1'b1) begin bad++; $display("FAIL b2b_ready_back: got %b want 1", istek_hazir_c); end
            end
        end
        total++; if ({bos_c, bolme_hazir_c} !== 2'b10) begin bad++; $display("FAIL b2b_idle_after: got %b want 10", {bos_c, bolme_hazir_c}); end
    endtask

    task automatic test_invalid_opcode();
        istek(4'h3, 32'd5, 32'd1, 5'd2);
        tick();
        istek_bitir();
        total++; if (gecersiz_c !== 1'b1) begin bad++; $display("FAIL inv_pulse: got %b want 1", gecersiz_c); end
        total++; if (bos_c !== 1'b1) begin bad++; $display("FAIL inv_bos: got %b want 1", bos_c); end
        tick();
        total++; if (gecersiz_c !== 1'b0) begin bad++; $display("FAIL inv_pulse_width: got %b want 0", gecersiz_c); end
        for (int i = 0; i < 3; i++) begin
            total++; if ({bolme_hazir_c, bos_c} !== 2'b01) begin bad++; $display("FAIL inv_no_issue: got %b want 01", {bolme_hazir_c, bos_c}); end
            tick();
        end
    endtask

    task automatic test_flush();
        istek(4'h1, 32'd10, 32'd2, 5'd1);
        tick();
        istek(4'h1, 32'd20, 32'd2, 5'd2);
        tick();
        istek(4'h1, 32'd30, 32'd2, 5'd4);
        tick();
        istek_bitir();
        total++; if (bolme_islec1_c !== 32'd10) begin bad++; $display("FAIL flush_inflight: got %0d want 10", bolme_islec1_c); end
        iptal_g = 1'b1;
        tick();
        iptal_g = 1'b0;
        tick();
        bolme_bitti_g = 1'b1;
        bolme_sonuc_g = 32'd5;
        tick();
        bolme_bitti_g = 1'b0;
        total++; if (sonuc_gecerli_c !== 1'b0) begin bad++; $display("FAIL flush_discard: got %b want 0", sonuc_gecerli_c); end
        total++; if (bos_c !== 1'b1) begin bad++; $display("FAIL flush_bos: got %b want 1", bos_c); end
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if ({bolme_hazir_c, sonuc_gecerli_c} !== 2'b00) begin bad++; $display("FAIL flush_quiet: got %b want 00", {bolme_hazir_c, sonuc_gecerli_c}); end
        end
        // Flush wins over a same-cycle enqueue.
        istek(4'h2, 32'd8, 32'd2, 5'd6);
        iptal_g = 1'b1;
        tick();
        istek_bitir();
        iptal_g = 1'b0;
        total++; if (bos_c !== 1'b1) begin bad++; $display("FAIL flush_prio_bos: got %b want 1", bos_c); end
        tick();
        total++; if ({bolme_hazir_c, bos_c} !== 2'b01) begin bad++; $display("FAIL flush_prio_noissue: got %b want 01", {bolme_hazir_c, bos_c}); end
    endtask

    task automatic test_hold();
        istek(4'h2, 32'd50, 32'd5, 5'd5);
        tick();
        istek(4'h2, 32'd8, 32'd2, 5'd6);
        tick();
        istek_bitir();
        tick();
        bolme_bitti_g = 1'b1;
        bolme_sonuc_g = 32'd10;
        tick();
        bolme_bitti_g = 1'b0;
        for (int i = 0; i < 10; i++) begin
            total++; if ({sonuc_gecerli_c, sonuc_c, sonuc_etiket_c, bolme_hazir_c} !== {1'b1, 32'd10, 5'd5, 1'b0}) begin bad++; $display("FAIL hold_stable[%0d]: got v=%b %0d t=%0d h=%b want v=1 10 t=5 h=0", i, sonuc_gecerli_c, sonuc_c, sonuc_etiket_c, bolme_hazir_c); end
            tick();
        end
        sonuc_hazir_g = 1'b1;
        tick();
        sonuc_hazir_g = 1'b0;
        total++; if ({bolme_hazir_c, bolme_islec1_c} !== {1'b1, 32'd8}) begin bad++; $display("FAIL hold_next_issue: got h=%b a=%0d want h=1 a=8", bolme_hazir_c, bolme_islec1_c); end
        tick();
        bolme_bitti_g = 1'b1;
        bolme_sonuc_g = 32'd4;
        tick();
        bolme_bitti_g = 1'b0;
        total++; if ({sonuc_c, sonuc_etiket_c} !== {32'd4, 5'd6}) begin bad++; $display("FAIL hold_second: got %0d t=%0d want 4 t=6", sonuc_c, sonuc_etiket_c); end
        sonuc_hazir_g = 1'b1;
        tick();
        sonuc_hazir_g = 1'b0;
    endtask

    task automatic test_timeout();
        istek(4'h1, 32'd1, 32'd1, 5'd1);
        tick();
        istek_bitir();
        tick();
        tick();
        // Now in the first BEKLE cycle; 63 quiet cycles, the 64th ends in timeout.
        for (int i = 0; i < 63; i++) begin
            tick();
            if (zaman_asimi_c !== 1'b0) begin total++; bad++; $display("FAIL timeout_early[%0d]: got 1 want 0", i); end
        end
        total++;
        tick();
        total++; if (zaman_asimi_c !== 1'b1) begin bad++; $display("FAIL timeout_pulse: got %b want 1", zaman_asimi_c); end
        total++; if (bos_c !== 1'b1) begin bad++; $display("FAIL timeout_bos: got %b want 1", bos_c); end
        bolme_bitti_g = 1'b1;
        bolme_sonuc_g = 32'd77;
        tick();
        bolme_bitti_g = 1'b0;
        total++; if ({zaman_asimi_c, sonuc_gecerli_c} !== 2'b00) begin bad++; $display("FAIL timeout_late_bitti: got %b want 00", {zaman_asimi_c, sonuc_gecerli_c}); end
    endtask

    task automatic test_async_reset();
        istek(4'h1, 32'd40, 32'd4, 5'd9);
        tick();
        istek(4'h1, 32'd60, 32'd3, 5'd10);
        tick();
        istek_bitir();
        tick();
        bolme_bitti_g = 1'b1;
        bolme_sonuc_g = 32'd10;
        tick();
        bolme_bitti_g = 1'b0;
        total++; if (sonuc_gecerli_c !== 1'b1) begin bad++; $display("FAIL arst_pre_gecerli: got %b want 1", sonuc_gecerli_c); end
        #2 rst_g = 1'b0;
        #1;
        total++; if ({sonuc_gecerli_c, sonuc_c} !== {1'b0, 32'd0}) begin bad++; $display("FAIL arst_sonuc: got v=%b %0d want v=0 0", sonuc_gecerli_c, sonuc_c); end
        total++; if ({bolme_islev_kodu_c, bolme_islec1_c} !== {4'h0, 32'd0}) begin bad++; $display("FAIL arst_issue: got %0h/%0d want 0/0", bolme_islev_kodu_c, bolme_islec1_c); end
        total++; if ({istek_hazir_c, bos_c} !== 2'b11) begin bad++; $display("FAIL arst_flags: got %b want 11", {istek_hazir_c, bos_c}); end
        tick();
        rst_g = 1'b1;
        bolme_bitti_g = 1'b1;
        tick();
        bolme_bitti_g = 1'b0;
        tick();
        total++; if ({sonuc_gecerli_c, bolme_hazir_c, bos_c} !== 3'b001) begin bad++; $display("FAIL arst_stray_bitti: got %b want 001", {sonuc_gecerli_c, bolme_hazir_c, bos_c}); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_invalid_opcode();
        test_flush();
        test_hold();
        test_timeout();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
